// File: rtl/floor_request_scheduler.sv
// Elevator call front end: debounces floor buttons into a pending bitmap and
// selects the next target floor with a SCAN (keep-direction) policy.
module floor_request_scheduler #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2,
  parameter int DEB_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req_btn,
  input  logic                  cancel_all,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  door_open,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      deb_cnt [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] accept;
  logic [NUM_FLOORS-1:0] pending_n;
  logic [FLOOR_W-1:0]    target_n;
  logic                  dir_n;

  logic up_found, dn_found, below_found, above_found, near_found;
  int   up_idx, dn_idx, below_idx, above_idx, near_idx, near_dist, cur;

  // Saturating counter: acceptance fires only on the step into DEB_MAX, so a
  // held button is taken once and must drop to zero before it can fire again.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (reset || !req_btn[i]) deb_cnt[i] <= '0;
      else if (deb_cnt[i] != DEB_MAX) deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
    end
  end

  always_comb begin
    accept    = '0;
    pending_n = pending;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      accept[i] = req_btn[i] && (deb_cnt[i] == DEB_MAX - CNT_W'(1));
    end
    pending_n = pending | accept;
    // Retiring the served floor wins over a press for that floor.
    if (door_open) begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (current_floor == FLOOR_W'(i)) pending_n[i] = 1'b0;
      end
    end
  end

  always_comb begin
    cur         = int'(current_floor);
    up_found    = 1'b0;
    dn_found    = 1'b0;
    below_found = 1'b0;
    above_found = 1'b0;
    near_found  = 1'b0;
    up_idx      = 0;
    dn_idx      = 0;
    below_idx   = 0;
    above_idx   = 0;
    near_idx    = 0;
    near_dist   = 0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && i <= cur) begin dn_found = 1'b1; dn_idx = i; end
      if (pending[i] && i < cur) begin below_found = 1'b1; below_idx = i; end
      // Ascending scan with <= lets the higher floor win a distance tie.
      if (pending[i] && (!near_found ||
          ((i > cur) ? i - cur : cur - i) <= near_dist)) begin
        near_found = 1'b1;
        near_idx   = i;
        near_dist  = (i > cur) ? i - cur : cur - i;
      end
    end
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && i >= cur) begin up_found = 1'b1; up_idx = i; end
      if (pending[i] && i > cur) begin above_found = 1'b1; above_idx = i; end
    end
  end

  always_comb begin
    state_n  = state;
    target_n = target_floor;
    dir_n    = dir_up;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          target_n = FLOOR_W'(near_idx);
          if (near_idx > cur)      state_n = UP;
          else if (near_idx < cur) state_n = DOWN;
        end
      end
      UP: begin
        if (pending == '0) state_n = IDLE;
        else if (up_found) target_n = FLOOR_W'(up_idx);
        else if (below_found) begin
          state_n  = DOWN;
          target_n = FLOOR_W'(below_idx);
        end
      end
      DOWN: begin
        if (pending == '0) state_n = IDLE;
        else if (dn_found) target_n = FLOOR_W'(dn_idx);
        else if (above_found) begin
          state_n  = UP;
          target_n = FLOOR_W'(above_idx);
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == UP)        dir_n = 1'b1;
    else if (state_n == DOWN) dir_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= '0;
      target_floor <= '0;
      target_valid <= 1'b0;
      dir_up       <= 1'b1;
    end else if (cancel_all) begin
      state        <= IDLE;
      pending      <= '0;
      target_valid <= 1'b0;
    end else begin
      pending      <= pending_n;
      target_valid <= (pending != '0);
      // Door interlock: the car is stopped, so only the call bitmap moves.
      if (!door_open) begin
        state        <= state_n;
        target_floor <= target_n;
        dir_up       <= dir_n;
      end
    end
  end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler: expected {pending, target_floor,
// target_valid, dir_up} words are queued with each step and popped after it.
module tb_floor_request_scheduler;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = 2;
  localparam int DEB_CYCLES = 3;
  localparam int W          = NUM_FLOORS + FLOOR_W + 2;

  logic                  clk;
  logic                  reset;
  logic [NUM_FLOORS-1:0] req_btn;
  logic                  cancel_all;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  door_open;
  logic [FLOOR_W-1:0]    target_floor;
  logic                  target_valid;
  logic                  dir_up;
  logic [NUM_FLOORS-1:0] pending;

  logic [W-1:0] exp_q[$];
  int checks;
  int failures;

  floor_request_scheduler #(
    .NUM_FLOORS(NUM_FLOORS),
    .FLOOR_W   (FLOOR_W),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_btn      (req_btn),
    .cancel_all   (cancel_all),
    .current_floor(current_floor),
    .door_open    (door_open),
    .target_floor (target_floor),
    .target_valid (target_valid),
    .dir_up       (dir_up),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] e(input logic [NUM_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0] tf,
                                     input logic tv, input logic du);
    return {p, tf, tv, du};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue the expected word, advance n edges, then pop and compare.
  task automatic run(input int n, input string tag, input logic [W-1:0] want);
    logic [W-1:0] got;
    logic [W-1:0] exp_v;
    exp_q.push_back(want);
    step(n);
    got   = {pending, target_floor, target_valid, dir_up};
    exp_v = exp_q.pop_front();
    checks++;
    assert (got === exp_v) else begin
      failures++;
      $error("FAIL %s got={p=%b tf=%0d tv=%b du=%b} want={p=%b tf=%0d tv=%b du=%b}",
             tag, got[W-1-:NUM_FLOORS], got[FLOOR_W+1:2], got[1], got[0],
             exp_v[W-1-:NUM_FLOORS], exp_v[FLOOR_W+1:2], exp_v[1], exp_v[0]);
    end
  endtask

  initial begin
    int f;
    int len;
    logic [NUM_FLOORS-1:0] one;
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    req_btn       = 4'b1111;
    cancel_all    = 1'b0;
    current_floor = 2'd0;
    door_open     = 1'b0;

    // Reset with every button held
    run(2, "t1_reset", e(4'b0000, 2'd0, 1'b0, 1'b1));
    reset = 1'b0; req_btn = 4'b0000;
    run(1, "t1_idle", e(4'b0000, 2'd0, 1'b0, 1'b1));

    // Basic call to floor 2 from floor 0
    req_btn = 4'b0100;
    run(2, "t2_edge2", e(4'b0000, 2'd0, 1'b0, 1'b1));
    run(1, "t2_edge3", e(4'b0100, 2'd0, 1'b0, 1'b1));
    req_btn = 4'b0000;
    run(1, "t2_edge4", e(4'b0100, 2'd2, 1'b1, 1'b1));
    current_floor = 2'd2; door_open = 1'b1;
    run(1, "t2_retire", e(4'b0000, 2'd2, 1'b1, 1'b1));
    door_open = 1'b0;
    run(1, "t2_idle", e(4'b0000, 2'd2, 1'b0, 1'b1));

    // Glitch reject, then held button retired while still held
    req_btn = 4'b1000;
    step(2);
    req_btn = 4'b0000;
    run(3, "t3_glitch", e(4'b0000, 2'd2, 1'b0, 1'b1));
    req_btn = 4'b1000;
    run(3, "t3_latch", e(4'b1000, 2'd2, 1'b0, 1'b1));
    run(1, "t3_target", e(4'b1000, 2'd3, 1'b1, 1'b1));
    current_floor = 2'd3; door_open = 1'b1;
    run(1, "t3_retire", e(4'b0000, 2'd3, 1'b1, 1'b1));
    door_open = 1'b0;
    run(5, "t3_held", e(4'b0000, 2'd3, 1'b0, 1'b1));
    req_btn = 4'b0000;
    run(1, "t3_release", e(4'b0000, 2'd3, 1'b0, 1'b1));

    // SCAN order: going up from 1 with calls at 3 and 0
    current_floor = 2'd1;
    req_btn = 4'b1000;
    run(3, "t4_p3", e(4'b1000, 2'd3, 1'b0, 1'b1));
    req_btn = 4'b0001;
    run(1, "t4_up", e(4'b1000, 2'd3, 1'b1, 1'b1));
    run(2, "t4_p1001", e(4'b1001, 2'd3, 1'b1, 1'b1));
    req_btn = 4'b0000;
    current_floor = 2'd3; door_open = 1'b1;
    run(1, "t4_retire3", e(4'b0001, 2'd3, 1'b1, 1'b1));
    door_open = 1'b0;
    run(1, "t4_reverse", e(4'b0001, 2'd0, 1'b1, 1'b0));

    // Same-floor press while the door is open
    current_floor = 2'd2; door_open = 1'b1;
    req_btn = 4'b0100;
    run(3, "t5_drop", e(4'b0001, 2'd0, 1'b1, 1'b0));
    req_btn = 4'b0000; door_open = 1'b0;
    run(1, "t5_down", e(4'b0001, 2'd0, 1'b1, 1'b0));

    // cancel_all on the accept edge of floor 1
    req_btn = 4'b0010;
    step(2);
    cancel_all = 1'b1;
    run(1, "t6_cancel", e(4'b0000, 2'd0, 1'b0, 1'b0));
    cancel_all = 1'b0;
    run(2, "t6_no_rearm", e(4'b0000, 2'd0, 1'b0, 1'b0));
    req_btn = 4'b0000;

    // Nearest-floor tie from IDLE goes to the higher floor
    current_floor = 2'd1;
    req_btn = 4'b0101;
    run(3, "tie_latch", e(4'b0101, 2'd0, 1'b0, 1'b0));
    req_btn = 4'b0000;
    run(1, "tie_pick", e(4'b0101, 2'd2, 1'b1, 1'b1));
    cancel_all = 1'b1;
    run(1, "tie_cancel", e(4'b0000, 2'd2, 1'b0, 1'b1));
    cancel_all = 1'b0;

    // Random short pulses never latch
    for (int k = 0; k < 4; k++) begin
      f   = $urandom_range(0, NUM_FLOORS - 1);
      len = $urandom_range(1, DEB_CYCLES - 1);
      one = 4'b0001;
      req_btn = one << f;
      step(len);
      req_btn = 4'b0000;
      run(1, "rand_glitch", e(4'b0000, 2'd2, 1'b0, 1'b1));
    end

    // Reset while travelling down with calls at 1 and 2
    current_floor = 2'd3;
    req_btn = 4'b0110;
    run(3, "t6_p0110", e(4'b0110, 2'd2, 1'b0, 1'b1));
    req_btn = 4'b0000;
    run(1, "t6_down", e(4'b0110, 2'd2, 1'b1, 1'b0));
    run(1, "t6_down_hold", e(4'b0110, 2'd2, 1'b1, 1'b0));
    reset = 1'b1;
    run(1, "t6_reset", e(4'b0000, 2'd0, 1'b0, 1'b1));
    reset = 1'b0;
    run(1, "t6_after", e(4'b0000, 2'd0, 1'b0, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
